hwpe_evt_irq_ctrl: RTL

HWPE_EVT_IRQ_CTRL -- requirements
Module: hwpe_evt_irq_ctrl

---
 rtl/hwpe_evt_irq_ctrl_pkg.sv | 30 +++
 rtl/hwpe_evt_irq_ctrl_popcount.sv | 24 ++
 rtl/hwpe_evt_irq_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/hwpe_evt_irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_evt_irq_ctrl_pkg
// Description : Shared register map, counter width and byte-enable helper for
//               the HWPE event-to-interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hwpe_evt_irq_ctrl_pkg;

  // Word offsets decoded from periph_addr_i[4:2]
  localparam logic [2:0] REG_PENDING   = 3'd0;
  localparam logic [2:0] REG_MASK      = 3'd1;
  localparam logic [2:0] REG_SET       = 3'd2;
  localparam logic [2:0] REG_EVT_COUNT = 3'd3;

  // Width of the saturating event counter
  localparam int unsigned EVT_COUNT_W = 32;

  // Expand 4 byte enables into a 32-bit bit mask
  function automatic logic [31:0] be_to_bitmask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hwpe_evt_irq_ctrl_popcount.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_evt_irq_ctrl_popcount
// Description : Combinational population count of an input vector.
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_evt_irq_ctrl_popcount #(
  parameter int unsigned INPUT_WIDTH = 9,
  localparam int unsigned CNT_W = $clog2(INPUT_WIDTH + 1)
) (
  input  logic [INPUT_WIDTH-1:0] data_i,
  output logic [CNT_W-1:0]       popcount_o
);

  // Ripple sum of all set bits
  always_comb begin
    popcount_o = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      popcount_o = popcount_o + CNT_W'(data_i[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hwpe_evt_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_evt_irq_ctrl
// Description : Latches per-core HWPE events into pending bits, masks them
//               onto the cores' mxip lines and counts events; controlled via
//               a zero-wait-state periph slave port.
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_evt_irq_ctrl
  import hwpe_evt_irq_ctrl_pkg::*;
#(
  parameter int unsigned NrCores   = 9,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NrCores-1:0]   hwpe_evt_i,
  input  logic [NrCores-1:0]   mxip_i,
  output logic [NrCores-1:0]   mxip_o,
  input  logic                 periph_req_i,
  output logic                 periph_gnt_o,
  input  logic [AddrWidth-1:0] periph_addr_i,
  input  logic                 periph_we_i,
  input  logic [3:0]           periph_be_i,
  input  logic [DataWidth-1:0] periph_wdata_i,
  output logic                 periph_rvalid_o,
  output logic [DataWidth-1:0] periph_rdata_o
);

  localparam int unsigned POP_W = $clog2(NrCores + 1);

  logic [NrCores-1:0]     pending_q, pending_d;
  logic [NrCores-1:0]     mask_q, mask_d;
  logic [EVT_COUNT_W-1:0] evt_count_q, evt_count_d;
  logic                   rvalid_q, rvalid_d;
  logic [31:0]            rdata_q, rdata_d;

  logic [POP_W-1:0]       evt_popcnt;
  logic [EVT_COUNT_W:0]   cnt_sum;
  logic [2:0]             reg_idx;
  logic                   wr_en, rd_en;
  logic [31:0]            be_mask;
  logic [NrCores-1:0]     be_bits, wr_bits;
  logic                   unused_bits;

  assign reg_idx      = periph_addr_i[4:2];
  assign wr_en        = periph_req_i &  periph_we_i;
  assign rd_en        = periph_req_i & ~periph_we_i;
  assign be_mask      = be_to_bitmask(periph_be_i);
  assign be_bits      = be_mask[NrCores-1:0];
  assign wr_bits      = periph_wdata_i[NrCores-1:0] & be_bits;
  assign unused_bits  = ^{periph_addr_i, periph_wdata_i};

  // No wait states: every request is accepted in the cycle it appears
  assign periph_gnt_o = periph_req_i;

  hwpe_evt_irq_ctrl_popcount #(
    .INPUT_WIDTH (NrCores)
  ) i_evt_popcount (
    .data_i     (hwpe_evt_i),
    .popcount_o (evt_popcnt)
  );

  // Pending: W1C then W1S, with new events applied last so a set always wins
  always_comb begin
    pending_d = pending_q;
    if (wr_en && (reg_idx == REG_PENDING)) pending_d = pending_d & ~wr_bits;
    if (wr_en && (reg_idx == REG_SET))     pending_d = pending_d | wr_bits;
    pending_d = pending_d | hwpe_evt_i;
  end

  // Mask: byte-enabled read-modify-write
  always_comb begin
    mask_d = mask_q;
    if (wr_en && (reg_idx == REG_MASK)) mask_d = (mask_q & ~be_bits) | wr_bits;
  end

  // Event counter: saturating accumulate; a clear restarts from this cycle's events
  always_comb begin
    cnt_sum     = {1'b0, evt_count_q} + (EVT_COUNT_W + 1)'(evt_popcnt);
    evt_count_d = cnt_sum[EVT_COUNT_W] ? '1 : cnt_sum[EVT_COUNT_W-1:0];
    if (wr_en && (reg_idx == REG_EVT_COUNT) && (|periph_be_i)) begin
      evt_count_d = EVT_COUNT_W'(evt_popcnt);
    end
  end

  // Response: one-cycle rvalid, data from pre-update register state, 0 for writes
  always_comb begin
    rvalid_d = periph_req_i;
    rdata_d  = '0;
    if (rd_en) begin
      case (reg_idx)
        REG_PENDING:   rdata_d = 32'(pending_q);
        REG_MASK:      rdata_d = 32'(mask_q);
        REG_EVT_COUNT: rdata_d = evt_count_q;
        default:       rdata_d = '0;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q   <= '0;
      mask_q      <= '1;
      evt_count_q <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      evt_count_q <= evt_count_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign periph_rvalid_o = rvalid_q;
  assign periph_rdata_o  = rdata_q;

  // External lines pass straight through; internal sources are suppressed in reset
  assign mxip_o = rst_ni ? ((pending_q & mask_q) | mxip_i) : mxip_i;

endmodule
`default_nettype wire
